// File: rtl/redmule_job_scheduler.sv
// redmule_job_scheduler: queues packed jobs and streams each as config writes plus a trigger write.
// Ports: job_valid_i/job_ready_o/job_cfg_i job input; periph_* master write port;
// evt_done_i end-of-job event; start_cfg_o last-config pulse; busy_o/pending_o status.
// clk_int clock, rst_ni async active-low reset, clear_i sync clear.
module redmule_job_scheduler #(
  parameter int unsigned NumCfgRegs = 6,
  parameter int unsigned SysDataWidth = 32,
  parameter int unsigned QueueDepth = 2,
  parameter logic [SysDataWidth-1:0] CfgBaseAddr = 'h40,
  parameter logic [SysDataWidth-1:0] TriggerAddr = 'h00
) (
  input  logic                                 clk_int,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 job_valid_i,
  output logic                                 job_ready_o,
  input  logic [NumCfgRegs*SysDataWidth-1:0]   job_cfg_i,
  output logic                                 periph_req_o,
  output logic [SysDataWidth-1:0]              periph_add_o,
  output logic                                 periph_wen_o,
  output logic [SysDataWidth/8-1:0]            periph_be_o,
  output logic [SysDataWidth-1:0]              periph_data_o,
  output logic                                 periph_id_o,
  input  logic                                 periph_gnt_i,
  input  logic                                 evt_done_i,
  output logic                                 start_cfg_o,
  output logic                                 busy_o,
  output logic [$clog2(QueueDepth+1)-1:0]      pending_o
);
  localparam int unsigned PtrW = $clog2(QueueDepth);
  localparam int unsigned CntW = $clog2(QueueDepth+1);
  localparam int unsigned IdxW = NumCfgRegs > 1 ? $clog2(NumCfgRegs) : 1;
  localparam int unsigned JobW = NumCfgRegs*SysDataWidth;
  typedef enum logic [1:0] {Idle, WriteCfg, Trigger, Wait} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [JobW-1:0] mem_q [QueueDepth];
  logic push, pop, in_wr, in_tr, last;
  always_comb begin
    in_wr = state_q == WriteCfg;
    in_tr = state_q == Trigger;
    job_ready_o = cnt_q < CntW'(QueueDepth);
    push = job_valid_i & job_ready_o;
    pop = in_tr & periph_gnt_i;
    last = in_wr & periph_gnt_i & (idx_q == IdxW'(NumCfgRegs-1));
    periph_req_o = in_wr | in_tr;
    periph_wen_o = 1'b0;
    periph_id_o = 1'b0;
    periph_be_o = periph_req_o ? '1 : '0;
    periph_add_o = in_wr ? CfgBaseAddr + (SysDataWidth'(idx_q) << 2) : in_tr ? TriggerAddr : '0;
    periph_data_o = in_wr ? mem_q[rptr_q][idx_q*SysDataWidth +: SysDataWidth] : '0;
    start_cfg_o = last;
    busy_o = state_q != Idle;
    pending_o = cnt_q;
    idx_d = (in_wr & periph_gnt_i) ? (last ? '0 : idx_q + IdxW'(1)) : idx_q;
    wptr_d = wptr_q + PtrW'(push);
    rptr_d = rptr_q + PtrW'(pop);
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    state_d = state_q == Idle ? (cnt_q != '0 ? WriteCfg : Idle) :
              last ? Trigger :
              pop ? Wait :
              (state_q == Wait && evt_done_i) ? Idle : state_q;
  end
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      idx_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      state_q <= Idle;
      idx_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_int) begin
    if (push) mem_q[wptr_q] <= job_cfg_i;
  end
endmodule

// File: tb/tb_redmule_job_scheduler.sv
// tb_redmule_job_scheduler: directed scoreboard bench for redmule_job_scheduler.
module tb_redmule_job_scheduler;
  logic clk = 0, rst_ni = 0, clear_i = 0, job_valid_i = 0, periph_gnt_i = 1, evt_done_i = 0;
  logic [191:0] job_cfg_i = '0;
  logic job_ready_o, periph_req_o, periph_wen_o, periph_id_o, start_cfg_o, busy_o;
  logic [31:0] periph_add_o, periph_data_o;
  logic [3:0] periph_be_o;
  logic [1:0] pending_o;
  typedef struct {logic [31:0] add; logic [31:0] data; logic last;} txn_t;
  txn_t sb[$];
  int checks = 0, errors = 0, grants = 0, n;
  redmule_job_scheduler dut (
    .clk_int(clk), .rst_ni(rst_ni), .clear_i(clear_i), .job_valid_i(job_valid_i),
    .job_ready_o(job_ready_o), .job_cfg_i(job_cfg_i), .periph_req_o(periph_req_o),
    .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o),
    .periph_data_o(periph_data_o), .periph_id_o(periph_id_o), .periph_gnt_i(periph_gnt_i),
    .evt_done_i(evt_done_i), .start_cfg_o(start_cfg_o), .busy_o(busy_o), .pending_o(pending_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [191:0] job(input logic [31:0] base);
    logic [191:0] j;
    for (int i = 0; i < 6; i++) j[i*32 +: 32] = base + i;
    return j;
  endfunction
  task automatic offer(input logic [191:0] cfg, input logic exp_ready);
    job_valid_i = 1;
    job_cfg_i = cfg;
    chk("job_ready", job_ready_o, exp_ready);
    if (exp_ready) begin
      for (int i = 0; i < 6; i++) sb.push_back('{32'h40 + 4*i, cfg[i*32 +: 32], i == 5});
      sb.push_back('{32'h0, 32'h0, 1'b0});
    end
    step();
    job_valid_i = 0;
  endtask
  task automatic wait_sb(input int target, output int cnt);
    cnt = 0;
    while (sb.size() > target && cnt < 100) begin
      step();
      cnt++;
    end
    chk("wait_sb", sb.size() <= target, 1);
  endtask
  task automatic done();
    evt_done_i = 1;
    step();
    evt_done_i = 0;
    chk("idle_after_done", busy_o, 0);
  endtask
  always @(negedge clk) if (rst_ni) begin
    if (periph_req_o && periph_gnt_i) begin
      txn_t e;
      grants++;
      chk("grant_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("add", periph_add_o, e.add);
        chk("data", periph_data_o, e.data);
        chk("start_cfg", start_cfg_o, e.last);
        chk("ctrl", {periph_wen_o, periph_be_o, periph_id_o}, 6'b0_1111_0);
      end
    end else begin
      chk("start_idle", start_cfg_o, 0);
      if (!periph_req_o) chk("idle_outs", {periph_add_o, periph_data_o, periph_be_o}, 0);
    end
  end
  initial begin
    step();
    step();
    chk("rst_state", {busy_o, pending_o, periph_req_o, job_ready_o, start_cfg_o}, 6'b0_00_0_1_0);
    rst_ni = 1;
    step();
    offer(job(32'h10), 1);
    chk("pending_single", pending_o, 1);
    chk("busy_idle_cycle", busy_o, 0);
    wait_sb(0, n);
    chk("latency", n, 8);
    chk("busy_wait", busy_o, 1);
    step();
    chk("no_req_wait", periph_req_o, 0);
    done();
    grants = 0;
    offer(job(32'h20), 1);
    step();
    step();
    step();
    periph_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_add", periph_add_o, 32'h48);
      chk("bp_data", periph_data_o, 32'h22);
      step();
    end
    periph_gnt_i = 1;
    wait_sb(0, n);
    chk("bp_grants", grants, 7);
    done();
    offer(job(32'h30), 1);
    offer(job(32'h50), 1);
    chk("full_pending", pending_o, 2);
    offer(job(32'h70), 0);
    chk("full_pending_after_c", pending_o, 2);
    wait_sb(7, n);
    chk("after_pop_pending", pending_o, 1);
    chk("after_pop_ready", job_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("order_no_req", periph_req_o, 0);
    end
    done();
    wait_sb(0, n);
    done();
    offer(job(32'h90), 1);
    wait_sb(1, n);
    chk("in_trigger_add", {periph_req_o, periph_add_o}, {1'b1, 32'h0});
    offer(job(32'hA0), 1);
    chk("push_pop_pending", pending_o, 1);
    done();
    wait_sb(0, n);
    done();
    offer(job(32'hB0), 1);
    offer(job(32'hC0), 1);
    step();
    step();
    step();
    chk("pre_clear_add", periph_add_o, 32'h4C);
    clear_i = 1;
    step();
    clear_i = 0;
    sb.delete();
    chk("clear_state", {busy_o, pending_o, periph_req_o, job_ready_o}, 5'b0_00_0_1);
    evt_done_i = 1;
    step();
    evt_done_i = 0;
    step();
    chk("stray_evt", {busy_o, periph_req_o, pending_o}, 4'b0);
    job_valid_i = 1;
    clear_i = 1;
    step();
    job_valid_i = 0;
    clear_i = 0;
    step();
    chk("clear_prio", {pending_o, busy_o}, 3'b0);
    offer(job(32'hD0), 1);
    wait_sb(0, n);
    chk("busy_before_rst", busy_o, 1);
    #2 rst_ni = 0;
    #1 chk("async_rst", {busy_o, pending_o, job_ready_o}, 4'b0_00_1);
    step();
    rst_ni = 1;
    step();
    chk("post_rst_idle", {busy_o, periph_req_o}, 2'b0);
    offer(job(32'hE0), 1);
    wait_sb(0, n);
    done();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/redmule_job_scheduler.md
REDMULE_JOB_SCHEDULER -- requirements
Module: redmule_job_scheduler

Interface
REQ-001 SHALL have parameter NumCfgRegs, default 6: configuration words per job, written at offsets 0..NumCfgRegs-1.
REQ-002 SHALL have parameter SysDataWidth, default 32: width of each config word and of periph data/address.
REQ-003 SHALL have parameter QueueDepth, default 2: pending-job capacity, power of two, >=2.
REQ-004 SHALL have parameter CfgBaseAddr, default 'h40: periph address of config word 0.
REQ-005 SHALL have parameter TriggerAddr, default 'h00: periph address written to trigger a job.
REQ-006 SHALL have port clk_int  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_int.
REQ-007 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-008 SHALL have port clear_i  in  1  synchronous clear, same effect as reset.
REQ-009 SHALL have port job_valid_i  in  1  job offered.
REQ-010 SHALL have port job_ready_o  out  1  job accepted when valid&ready.
REQ-011 SHALL have port job_cfg_i  in  NumCfgRegs*SysDataWidth  packed job words, word i at bits [i*SysDataWidth +: SysDataWidth].
REQ-012 SHALL have periph master ports periph_req_o (1), periph_add_o (SysDataWidth), periph_wen_o (1, 0 = write), periph_be_o (SysDataWidth/8), periph_data_o (SysDataWidth), periph_id_o (1); input periph_gnt_i (1).
REQ-013 SHALL have port evt_done_i  in  1  single-cycle accelerator end-of-job event.
REQ-014 SHALL have port start_cfg_o  out  1  one-cycle pulse when last config word is granted.
REQ-015 SHALL have ports busy_o  out  1  (state != Idle) and pending_o  out  $clog2(QueueDepth+1)  queued-job count.

Function
REQ-016 SHALL buffer accepted jobs in a FIFO of QueueDepth entries; job_ready_o = (pending_o < QueueDepth), derived from registered count only.
REQ-017 SHALL push on job_valid_i & job_ready_o; pop on Trigger-state grant; simultaneous push and pop leave pending_o unchanged; read/write pointers wrap modulo QueueDepth.
REQ-018 SHALL implement FSM Idle, WriteCfg, Trigger, Wait with a word counter idx (0..NumCfgRegs-1).
REQ-019 Idle: if pending_o != 0 -> WriteCfg with idx=0; job pushed in the same cycle is not seen until next cycle.
REQ-020 WriteCfg: periph_req_o=1, wen=0, be all ones, id=0, add=CfgBaseAddr+4*idx, data=head job word idx; on gnt idx++; on gnt with idx=NumCfgRegs-1: start_cfg_o=1, idx<=0, -> Trigger.
REQ-021 WriteCfg without gnt SHALL hold address and data stable (no idx advance).
REQ-022 Trigger: req=1, wen=0, be all ones, add=TriggerAddr, data=0; on gnt pop FIFO, -> Wait.
REQ-023 Wait: no periph request; on evt_done_i -> Idle; evt_done_i in any other state SHALL be ignored.
REQ-024 Each job SHALL cost exactly NumCfgRegs+1 granted transfers; jobs SHALL be issued strictly in acceptance order, never overlapping (next WriteCfg only after evt_done_i).
REQ-025 With gnt tied high, minimum latency from Idle with pending job to trigger grant SHALL be NumCfgRegs+2 cycles (1 Idle + NumCfgRegs WriteCfg + 1 Trigger).
REQ-026 All periph outputs SHALL be 0 outside WriteCfg/Trigger.
REQ-027 FIFO storage SHALL not require reset; only pointers, count, idx and state are reset.

Reset
REQ-028 On rst_ni low (async) or clear_i high (sync, at clock edge): state=Idle, idx=0, FIFO empty, pending_o=0, busy_o=0, start_cfg_o=0, periph_req_o=0, job_ready_o=1.
REQ-029 Reset/clear mid-WriteCfg or mid-Wait SHALL discard the in-flight and all queued jobs; no further periph request until a new job is accepted.
REQ-030 clear_i SHALL take priority over a push or pop in the same cycle.

Verification
REQ-031 Single job, gnt=1: words 'h10..'h15 -> writes to 'h40,'h44,..,'h54 with those data, start_cfg_o on 'h54 cycle, then write 0 to 'h00; busy_o until evt_done_i.
REQ-032 Backpressure: gnt low 3 cycles on word 2 -> add 'h48/data word 2 held stable 3 cycles, exactly 7 grants total.
REQ-033 Queue full: push 3 jobs back-to-back with no evt_done_i -> first two accepted, job_ready_o=0 after second pending; after first trigger grant pending_o=1 and job_ready_o=1.
REQ-034 Ordering: jobs A,B queued -> A config+trigger, no periph req until evt_done_i, then B config+trigger.
REQ-035 Push and pop same cycle with pending_o=1 -> pending_o stays 1.
REQ-036 clear_i asserted mid-WriteCfg (idx=3) with 1 queued job -> next cycle Idle, pending_o=0, periph_req_o=0; stray evt_done_i ignored.
